// File: rtl/oled_arb_pkg.sv
// oled_arb_pkg: shared types and constants for the OLED write arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE, FILL, DONE)
//   - *_DEF       : default display geometry and pixel width
//   - STALL_MAX   : saturation value of the fill stall counter
package oled_arb_pkg;

    localparam int unsigned N_COLS_DEF = 96;
    localparam int unsigned N_ROWS_DEF = 64;
    localparam int unsigned COL_W_DEF  = 7;
    localparam int unsigned ROW_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF = 24;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/oled_raster_counter.sv
// oled_raster_counter: raster-order pixel position generator for the fill engine.
// Ports:
//   CLK, RESET_N      clock / asynchronous active-low reset
//   load              load position to (col0,row0)
//   advance           step one pixel: column up, wrapping to col0 with row up after col1
//   col0/row0         top-left bound (inclusive)
//   col1/row1         bottom-right bound (inclusive)
//   col/row           current position
//   last              current position is (col1,row1)
module oled_raster_counter #(
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             load,
    input  logic             advance,
    input  logic [COL_W-1:0] col0,
    input  logic [ROW_W-1:0] row0,
    input  logic [COL_W-1:0] col1,
    input  logic [ROW_W-1:0] row1,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= col0;
            row <= row0;
        end else if (advance) begin
            if (col == col1) begin
                col <= col0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (col == col1) && (row == row1);

endmodule

// File: rtl/oled_write_arbiter.sv
// oled_write_arbiter: shares the OLED pixel-write port between CPU stores and a
// rectangle-fill engine. CPU writes always win; the fill stalls on those cycles.
// Optional build macro: OLED_ARB_STATS_EN enables the fill stall counter,
// otherwise stall_count is tied to zero.
// Ports:
//   CLK, RESET_N                     clock / asynchronous active-low reset
//   cpu_wr/cpu_col/cpu_row/cpu_data  CPU pixel write (never stalled)
//   fill_start, fill_col0/row0/col1/row1, fill_colour, fill_abort  fill control
//   fill_busy                        FSM in FILL
//   fill_done                        one-cycle pulse after a fill completes
//   stall_count                      CPU-stall cycles of the current/last fill
//   OLED_Write/Col/Row/Data          registered pixel-write port
module oled_write_arbiter
    import oled_arb_pkg::*;
#(
    parameter int unsigned N_COLS = N_COLS_DEF,
    parameter int unsigned N_ROWS = N_ROWS_DEF,
    parameter int unsigned COL_W  = COL_W_DEF,
    parameter int unsigned ROW_W  = ROW_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              cpu_wr,
    input  logic [COL_W-1:0]  cpu_col,
    input  logic [ROW_W-1:0]  cpu_row,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              fill_start,
    input  logic [COL_W-1:0]  fill_col0,
    input  logic [ROW_W-1:0]  fill_row0,
    input  logic [COL_W-1:0]  fill_col1,
    input  logic [ROW_W-1:0]  fill_row1,
    input  logic [DATA_W-1:0] fill_colour,
    input  logic              fill_abort,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [15:0]       stall_count,
    output logic              OLED_Write,
    output logic [COL_W-1:0]  OLED_Col,
    output logic [ROW_W-1:0]  OLED_Row,
    output logic [DATA_W-1:0] OLED_Data
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROWS - 1);

    arb_state_t state_q, state_d;

    logic [COL_W-1:0]  c0_cl, c1_cl, c0_q, c1_q, bnd_c0, bnd_c1, cur_col;
    logic [ROW_W-1:0]  r0_cl, r1_cl, r0_q, r1_q, bnd_r0, bnd_r1, cur_row;
    logic [DATA_W-1:0] colour_q;
    logic              empty, accept, load, advance, last;
    logic              issue_wr;
    logic [COL_W-1:0]  issue_col;
    logic [ROW_W-1:0]  issue_row;
    logic [DATA_W-1:0] issue_data;
    logic              done_q;

    assign c0_cl  = (fill_col0 > COL_MAX) ? COL_MAX : fill_col0;
    assign c1_cl  = (fill_col1 > COL_MAX) ? COL_MAX : fill_col1;
    assign r0_cl  = (fill_row0 > ROW_MAX) ? ROW_MAX : fill_row0;
    assign r1_cl  = (fill_row1 > ROW_MAX) ? ROW_MAX : fill_row1;
    assign empty  = (c0_cl > c1_cl) || (r0_cl > r1_cl);
    assign accept = (state_q == IDLE) && fill_start;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            c0_q     <= '0;
            c1_q     <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            colour_q <= '0;
        end else if (accept) begin
            c0_q     <= c0_cl;
            c1_q     <= c1_cl;
            r0_q     <= r0_cl;
            r1_q     <= r1_cl;
            colour_q <= fill_colour;
        end
    end

    // The counter loads in IDLE, before the bound registers are written, so it
    // sees the clamped inputs there and the latched bounds while filling.
    assign bnd_c0 = (state_q == IDLE) ? c0_cl : c0_q;
    assign bnd_c1 = (state_q == IDLE) ? c1_cl : c1_q;
    assign bnd_r0 = (state_q == IDLE) ? r0_cl : r0_q;
    assign bnd_r1 = (state_q == IDLE) ? r1_cl : r1_q;

    oled_raster_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_raster (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (load),
        .advance (advance),
        .col0    (bnd_c0),
        .row0    (bnd_r0),
        .col1    (bnd_c1),
        .row1    (bnd_r1),
        .col     (cur_col),
        .row     (cur_row),
        .last    (last)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fill_start) state_d = empty ? DONE : FILL;
            FILL: begin
                if (fill_abort)          state_d = IDLE;
                else if (advance && last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write selection: CPU first, fill pixel only when the CPU is quiet.
    always_comb begin
        issue_wr   = 1'b0;
        issue_col  = cpu_col;
        issue_row  = cpu_row;
        issue_data = cpu_data;
        advance    = 1'b0;
        load       = accept && !empty;
        if (cpu_wr) begin
            issue_wr = 1'b1;
        end else if (state_q == FILL) begin
            issue_wr   = 1'b1;
            issue_col  = cur_col;
            issue_row  = cur_row;
            issue_data = colour_q;
            advance    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OLED_Write <= 1'b0;
            OLED_Col   <= '0;
            OLED_Row   <= '0;
            OLED_Data  <= '0;
            done_q     <= 1'b0;
        end else begin
            OLED_Write <= issue_wr;
            done_q     <= (state_q == DONE);
            if (issue_wr) begin
                OLED_Col  <= issue_col;
                OLED_Row  <= issue_row;
                OLED_Data <= issue_data;
            end
        end
    end

    // fill_done is registered like the pixel port, so it follows the last
    // pixel's OLED_Write pulse by one cycle.
    assign fill_busy = (state_q == FILL);
    assign fill_done = done_q;

`ifdef OLED_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if ((state_q == FILL) && cpu_wr && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_oled_write_arbiter.sv
// Directed self-checking bench for oled_write_arbiter.
module tb_oled_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [6:0]  cpu_col = '0;
    logic [5:0]  cpu_row = '0;
    logic [23:0] cpu_data = '0;
    logic        fill_start = 1'b0;
    logic [6:0]  fill_col0 = '0, fill_col1 = '0;
    logic [5:0]  fill_row0 = '0, fill_row1 = '0;
    logic [23:0] fill_colour = '0;
    logic        fill_abort = 1'b0;
    logic        fill_busy, fill_done, OLED_Write;
    logic [15:0] stall_count;
    logic [6:0]  OLED_Col;
    logic [5:0]  OLED_Row;
    logic [23:0] OLED_Data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int busy_cnt = 0;
    int s;
    logic [36:0] wq[$];
    int          wcyc[$];

    oled_write_arbiter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .cpu_wr      (cpu_wr),
        .cpu_col     (cpu_col),
        .cpu_row     (cpu_row),
        .cpu_data    (cpu_data),
        .fill_start  (fill_start),
        .fill_col0   (fill_col0),
        .fill_row0   (fill_row0),
        .fill_col1   (fill_col1),
        .fill_row1   (fill_row1),
        .fill_colour (fill_colour),
        .fill_abort  (fill_abort),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .stall_count (stall_count),
        .OLED_Write  (OLED_Write),
        .OLED_Col    (OLED_Col),
        .OLED_Row    (OLED_Row),
        .OLED_Data   (OLED_Data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record the write stream and status pulses mid-cycle.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (OLED_Write) begin
                wq.push_back({OLED_Col, OLED_Row, OLED_Data});
                wcyc.push_back(cyc);
            end
            if (fill_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (fill_busy) busy_cnt = busy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] px(input logic [6:0] c, input logic [5:0] r,
                                       input logic [23:0] d);
        return {c, r, d};
    endfunction

    task automatic chk_wr(input string tag, input int idx, input logic [36:0] exp);
        logic [36:0] obs;
        obs = (idx < wq.size()) ? wq[idx] : 'x;
        chk(tag, {27'd0, obs}, {27'd0, exp});
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr;
        wq.delete();
        wcyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
    endtask

    // Drives a one-cycle fill_start; returns in the first FILL cycle.
    task automatic start_fill(input logic [6:0] c0, input logic [5:0] r0,
                              input logic [6:0] c1, input logic [5:0] r1,
                              input logic [23:0] colour);
        fill_col0   = c0;
        fill_row0   = r0;
        fill_col1   = c1;
        fill_row1   = r1;
        fill_colour = colour;
        fill_start  = 1'b1;
        tick();
        fill_start  = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset_outputs", {OLED_Write, OLED_Col, OLED_Row, OLED_Data, fill_busy, fill_done},
            64'd0);
        chk("reset_stall", stall_count, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        // CPU pass-through in IDLE, then hold of last values
        clr();
        cpu_wr = 1'b1; cpu_col = 7'd7; cpu_row = 6'd5; cpu_data = 24'h0ABCDE;
        tick();
        cpu_wr = 1'b0;
        chk("idle_cpu_write", {OLED_Write, OLED_Col, OLED_Row, OLED_Data},
            {1'b1, 7'd7, 6'd5, 24'h0ABCDE});
        tick();
        chk("idle_cpu_hold", {OLED_Write, OLED_Col, OLED_Row, OLED_Data},
            {1'b0, 7'd7, 6'd5, 24'h0ABCDE});

        // Basic fill (2,3)-(4,4)
        clr();
        start_fill(7'd2, 6'd3, 7'd4, 6'd4, 24'h00FF00);
        repeat (12) tick();
        chk("basic_count", wq.size(), 6);
        chk_wr("basic_px0", 0, px(7'd2, 6'd3, 24'h00FF00));
        chk_wr("basic_px1", 1, px(7'd3, 6'd3, 24'h00FF00));
        chk_wr("basic_px2", 2, px(7'd4, 6'd3, 24'h00FF00));
        chk_wr("basic_px3", 3, px(7'd2, 6'd4, 24'h00FF00));
        chk_wr("basic_px4", 4, px(7'd3, 6'd4, 24'h00FF00));
        chk_wr("basic_px5", 5, px(7'd4, 6'd4, 24'h00FF00));
        chk("basic_busy_cycles", busy_cnt, 6);
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_done_timing", done_cyc, (wcyc.size() == 6) ? wcyc[5] + 1 : -2);
        chk("basic_stall", stall_count, 0);

        // CPU preemption on the 2nd FILL cycle
        clr();
        start_fill(7'd2, 6'd3, 7'd4, 6'd4, 24'h00FF00);
        tick();
        cpu_wr = 1'b1; cpu_col = 7'd10; cpu_row = 6'd10; cpu_data = 24'hFF0000;
        tick();
        cpu_wr = 1'b0;
        repeat (12) tick();
        chk("preempt_count", wq.size(), 7);
        chk_wr("preempt_px0", 0, px(7'd2, 6'd3, 24'h00FF00));
        chk_wr("preempt_cpu", 1, px(7'd10, 6'd10, 24'hFF0000));
        chk_wr("preempt_px2", 2, px(7'd3, 6'd3, 24'h00FF00));
        chk_wr("preempt_px6", 6, px(7'd4, 6'd4, 24'h00FF00));
        chk("preempt_busy_cycles", busy_cnt, 7);
        chk("preempt_done_pulses", done_cnt, 1);
`ifdef OLED_ARB_STATS_EN
        chk("preempt_stall", stall_count, 1);
`else
        chk("preempt_stall", stall_count, 0);
`endif

        // Empty rectangle
        clr();
        s = cyc;
        start_fill(7'd5, 6'd0, 7'd4, 6'd0, 24'h111111);
        repeat (6) tick();
        chk("empty_count", wq.size(), 0);
        chk("empty_done_pulses", done_cnt, 1);
        chk("empty_done_timing", done_cyc - s, 2);
        chk("empty_busy_cycles", busy_cnt, 0);
        chk("empty_stall_cleared", stall_count, 0);

        // Clamped rectangle
        clr();
        start_fill(7'd94, 6'd63, 7'd127, 6'd63, 24'h123456);
        repeat (8) tick();
        chk("clamp_count", wq.size(), 2);
        chk_wr("clamp_px0", 0, px(7'd94, 6'd63, 24'h123456));
        chk_wr("clamp_px1", 1, px(7'd95, 6'd63, 24'h123456));
        chk("clamp_done_pulses", done_cnt, 1);

        // Abort in the 11th FILL cycle: its pixel still issues
        clr();
        start_fill(7'd0, 6'd0, 7'd95, 6'd63, 24'h0000FF);
        repeat (10) tick();
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        chk("abort_busy_next", fill_busy, 0);
        repeat (5) tick();
        chk("abort_count", wq.size(), 11);
        chk_wr("abort_last_px", 10, px(7'd10, 6'd0, 24'h0000FF));
        chk("abort_done_pulses", done_cnt, 0);

        // fill_start during FILL is ignored
        clr();
        start_fill(7'd2, 6'd3, 7'd4, 6'd4, 24'h0000AA);
        tick();
        fill_col0 = 7'd0; fill_row0 = 6'd0; fill_col1 = 7'd1; fill_row1 = 6'd1;
        fill_colour = 24'h0000BB;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (12) tick();
        chk("ignore_count", wq.size(), 6);
        chk_wr("ignore_px0", 0, px(7'd2, 6'd3, 24'h0000AA));
        chk_wr("ignore_px3", 3, px(7'd2, 6'd4, 24'h0000AA));
        chk_wr("ignore_px5", 5, px(7'd4, 6'd4, 24'h0000AA));
        chk("ignore_done_pulses", done_cnt, 1);

        // Reset mid-fill
        clr();
        start_fill(7'd0, 6'd0, 7'd95, 6'd63, 24'hFFFFFF);
        repeat (98) tick();
        chk("midfill_active", {OLED_Write, fill_busy}, 2'b11);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midfill_reset_outputs",
            {OLED_Write, OLED_Col, OLED_Row, OLED_Data, fill_busy, fill_done}, 64'd0);
        chk("midfill_reset_stall", stall_count, 0);
        tick();
        tick();
        RESET_N = 1'b1;
        clr();
        repeat (5) tick();
        chk("midfill_busy_after", busy_cnt, 0);
        chk("midfill_done_after", done_cnt, 0);
        chk("midfill_writes_after", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
